// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO controller for an external 16x8 single-port synchronous SRAM.
// The head word sits in the SRAM output register; this block only tracks pointers, count and head validity.
module sram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   level,
  output logic              sram_cs,
  output logic              sram_rw_bar,
  output logic [ADDR_W-1:0] sram_abus,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  localparam logic [ADDR_W:0]   DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   mem_cnt_q, mem_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              fetch, push, in_ready_int;

  // Reads win the single SRAM port; the writer only starves while the consumer drains every cycle.
  always_comb begin
    fetch        = (mem_cnt_q != '0) && (!out_valid_q || out_ready);
    in_ready_int = !rst && (mem_cnt_q != DEPTH_C) && !fetch;
    push         = in_valid && in_ready_int;
    sram_cs      = 1'b0;
    sram_rw_bar  = 1'b1;
    sram_abus    = rd_ptr_q;
    if (!rst) begin
      if (fetch) begin
        sram_cs = 1'b1;
      end else if (push) begin
        sram_cs     = 1'b1;
        sram_rw_bar = 1'b0;
        sram_abus   = wr_ptr_q;
      end
    end
  end

  always_comb begin
    wr_ptr_d    = push  ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = fetch ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    mem_cnt_d   = mem_cnt_q;
    if (push) begin
      mem_cnt_d = mem_cnt_q + CNT_ONE;
    end else if (fetch) begin
      mem_cnt_d = mem_cnt_q - CNT_ONE;
    end
    out_valid_d = fetch || (out_valid_q && !out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_int;
  assign out_valid = out_valid_q;
  assign out_data  = sram_dout;
  assign sram_din  = in_data;
  assign level     = mem_cnt_q + {{ADDR_W{1'b0}}, out_valid_q};

endmodule
